pll_reset_sequencer: RTL and testbench

- Sequences design-wide reset release behind the iCE40 PLL.
- Runs on the PLL output clock. Watches the PLL LOCK output, requires lock to stay high for a programmable number of cycles, then releases NUM_STAGES reset domains in order, one every STAGE_GAP cycles.
- Re-asserts all reset domains when lock is lost or when a soft-reset handshake is issued.
- Sits between the PLL wrapper and the top-level design units: memory controllers on stage 0, cores on stage 1, peripherals on stage 2.

---
 rtl/pll_seq_pkg.sv | 19 +
 rtl/sync2.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// default timing constants and a small elaboration-time helper.
package pll_seq_pkg;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP     = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset to 0.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release behind the PLL lock, with lock-loss and soft-reset re-arm.
// Optional lock-loss counter output enabled by `define PLL_RESET_SEQ_LOSS_COUNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter  int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter  int NUM_STAGES    = 3,
  parameter  int STAGE_GAP     = DEF_STAGE_GAP,
  localparam int CNT_W         = $clog2(max_int(STABLE_CYCLES, STAGE_GAP)) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] rst_stage,
  output logic                  ready,
  output logic                  lock_lost
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0]            loss_count
`endif
);

  localparam logic [CNT_W-1:0]      STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      GAP_CNT    = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0]      ONE_CNT    = CNT_W'(1);
  localparam logic [2:0]            LAST_IDX   = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE_STG    = NUM_STAGES'(1);

  seq_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2:0]            r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_rst_stage, w_rst_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_soft_ack, w_ack_nxt;
  logic                  r_lock_lost, w_lost_nxt;
  logic                  r_soft_armed, w_armed_nxt;
  logic                  w_lock_s;
  logic                  w_running;

  sync2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_running = (r_state == RELEASE) || (r_state == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_rst_stage  <= '1;
      r_ready      <= 1'b0;
      r_soft_ack   <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_soft_armed <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_rst_stage  <= w_rst_nxt;
      r_ready      <= w_ready_nxt;
      r_soft_ack   <= w_ack_nxt;
      r_lock_lost  <= w_lost_nxt;
      r_soft_armed <= w_armed_nxt;
    end
  end

  // Lock loss outranks the soft request, which outranks normal sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_stage;
    w_ready_nxt = r_ready;
    w_ack_nxt   = 1'b0;
    w_lost_nxt  = r_lock_lost;
    w_armed_nxt = soft_req ? r_soft_armed : 1'b1;

    if (w_running && !w_lock_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_lost_nxt  = 1'b1;
    end else if (w_running && soft_req && r_soft_armed) begin
      w_state_nxt = STABLE;
      w_cnt_nxt   = ONE_CNT;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_ack_nxt   = 1'b1;
      w_armed_nxt = 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
          if (w_lock_s) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = ONE_CNT;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_CNT) begin
            w_rst_nxt = r_rst_stage & ~ONE_STG;
            w_idx_nxt = 3'd1;
            w_cnt_nxt = ONE_CNT;
            if (NUM_STAGES == 1) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = RELEASE;
            end
          end else begin
            w_cnt_nxt = r_cnt + ONE_CNT;
          end
        end
        RELEASE: begin
          if (r_cnt == GAP_CNT) begin
            w_rst_nxt = r_rst_stage & ~(ONE_STG << r_idx);
            w_idx_nxt = r_idx + 3'd1;
            w_cnt_nxt = ONE_CNT;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + ONE_CNT;
          end
        end
        RUN: begin
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
        end
      endcase
    end
  end

  assign soft_ack  = r_soft_ack;
  assign rst_stage = r_rst_stage;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] r_loss_count;
  logic       w_loss_evt;

  assign w_loss_evt = w_running && !w_lock_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loss_count <= '0;
    end else if (w_loss_evt && (r_loss_count != 8'hFF)) begin
      r_loss_count <= r_loss_count + 8'd1;
    end
  end

  assign loss_count = r_loss_count;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: fixed vector table, corner-case
// sequences and randomized stimulus against a timestamp-based reference model.
module tb_pll_reset_sequencer;

  localparam int S = 8;
  localparam int N = 3;
  localparam int G = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         pll_lock;
  logic         soft_req;
  logic         soft_ack;
  logic [N-1:0] rst_stage;
  logic         ready;
  logic         lock_lost;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0]   loss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pll_reset_sequencer #(
    .STABLE_CYCLES (S),
    .NUM_STAGES    (N),
    .STAGE_GAP     (G)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .soft_req  (soft_req),
    .soft_ack  (soft_ack),
    .rst_stage (rst_stage),
    .ready     (ready),
    .lock_lost (lock_lost)
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  // Reference model: tracks the edge at which the current lock window started
  // and derives every stage release from elapsed edges.
  logic m_meta, m_lock_s, m_active, m_lost, m_ack, m_armed;
  int   m_n, m_start, m_loss;

  task automatic modelReset();
    m_meta = 0; m_lock_s = 0; m_active = 0; m_lost = 0; m_ack = 0; m_armed = 1;
    m_n = 0; m_start = 0; m_loss = 0;
  endtask

  task automatic modelEdge();
    logic done_before;
    m_n++;
    m_ack = 0;
    done_before = m_active && ((m_n - 1 - m_start) >= S);
    if (!m_active) begin
      if (m_lock_s) begin
        m_active = 1;
        m_start  = m_n;
      end
    end else if (!m_lock_s) begin
      if (done_before) begin
        m_lost = 1;
        if (m_loss < 255) m_loss++;
      end
      m_active = 0;
    end else if (done_before && soft_req && m_armed) begin
      m_ack   = 1;
      m_armed = 0;
      m_start = m_n;
    end
    if (!soft_req) m_armed = 1;
    m_lock_s = m_meta;
    m_meta   = pll_lock;
  endtask

  function automatic logic [N+2:0] modelOut();
    logic [N-1:0] r;
    logic         rd;
    r  = '1;
    rd = 0;
    if (m_active) begin
      int e;
      e = m_n - m_start;
      for (int k = 0; k < N; k++) r[k] = !(e >= S + k * G);
      rd = (e >= S + (N - 1) * G);
    end
    return {r, rd, m_ack, m_lost};
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq(tag, 32'({rst_stage, ready, soft_ack, lock_lost}), 32'(modelOut()));
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    checkEq({tag, "_loss"}, 32'(loss_count), 32'(m_loss));
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) modelEdge();
    #1;
    checkOutput("model");
  endtask

  task automatic applyStimulus(input logic lk, input logic sr, input int n);
    pll_lock = lk;
    soft_req = sr;
    repeat (n) tick();
  endtask

  task automatic doReset(input logic lk);
    reset    = 1;
    pll_lock = lk;
    soft_req = 0;
    modelReset();
    #1;
    checkEq("reset_state", 32'({rst_stage, ready, soft_ack, lock_lost}), 32'(6'b111_000));
    repeat (5) tick();
    #2;
    reset = 0;
  endtask

  typedef struct {
    logic         lk;
    logic         sr;
    int           n;
    logic [N-1:0] rst;
    logic         rdy;
    logic         ack;
    logic         lost;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int acks;

    tbl[0]  = '{1'b1, 1'b0, 10, 3'b111, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1,  3'b110, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3,  3'b110, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1,  3'b100, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3,  3'b100, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1,  3'b000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 5,  3'b000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2,  3'b000, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1,  3'b111, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 10, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1,  3'b110, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8,  3'b000, 1'b1, 1'b0, 1'b1};

    reset    = 0;
    pll_lock = 0;
    soft_req = 0;
    #2;

    // Power-on release, lock loss in RUN and re-lock
    doReset(1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].lk, tbl[i].sr, tbl[i].n);
      checkEq($sformatf("vec%0d", i), 32'({rst_stage, ready, soft_ack, lock_lost}),
              32'({tbl[i].rst, tbl[i].rdy, tbl[i].ack, tbl[i].lost}));
    end

    // One-cycle lock glitch while counting the stable window
    doReset(1'b1);
    applyStimulus(1, 0, 5);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 10);
    checkEq("glitch_hold", 32'(rst_stage), 32'(3'b111));
    applyStimulus(1, 0, 1);
    checkEq("glitch_stage0", 32'(rst_stage), 32'(3'b110));
    checkEq("glitch_lost", 32'(lock_lost), 32'(1'b0));
    applyStimulus(1, 0, 8);
    checkEq("glitch_ready", 32'(ready), 32'(1'b1));

    // Held soft request in RUN: one ack, full re-release
    acks = 0;
    pll_lock = 1;
    soft_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (soft_ack) acks++;
      if (i == 0) checkEq("soft_first", 32'({rst_stage, soft_ack}), 32'(4'b111_1));
      if (i == 8) checkEq("soft_stage0", 32'(rst_stage), 32'(3'b110));
      if (i == 12) checkEq("soft_stage1", 32'(rst_stage), 32'(3'b100));
      if (i == 16) checkEq("soft_ready", 32'({rst_stage, ready}), 32'(4'b000_1));
    end
    checkEq("soft_ack_count", 32'(acks), 32'(1));
    applyStimulus(1, 0, 3);

    // Lock loss seen on the same edge as a new soft request
    applyStimulus(0, 0, 2);
    applyStimulus(0, 1, 1);
    checkEq("simul", 32'({rst_stage, ready, soft_ack, lock_lost}), 32'(6'b111_001));
    applyStimulus(0, 1, 2);
    applyStimulus(1, 1, 14);
    applyStimulus(1, 0, 20);

    // Async reset mid-release, no clock edge needed
    doReset(1'b1);
    applyStimulus(1, 0, 12);
    checkEq("pre_async", 32'(rst_stage), 32'(3'b110));
    #2;
    reset = 1;
    modelReset();
    #1;
    checkEq("async_rst", 32'({rst_stage, ready}), 32'(4'b111_0));
    tick();
    #2;
    reset = 0;

    // Randomized lock drops and soft requests
    pll_lock = 1;
    soft_req = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pll_lock) begin
        if ($urandom_range(0, 99) < 1) pll_lock = 0;
      end else if ($urandom_range(0, 99) < 30) begin
        pll_lock = 1;
      end
      if ($urandom_range(0, 99) < 5) soft_req = ~soft_req;
      tick();
    end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    doReset(1'b1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 0, 12);
      applyStimulus(0, 0, 3);
      if (i == 9) checkEq("loss_count_10", 32'(loss_count), 32'(10));
    end
    checkEq("loss_count_sat", 32'(loss_count), 32'(255));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
